// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks up the local line, answers on CR/CD,
// then issues the line-state update. Optional lookup error reporting under ACE_SNOOP_RESP_ERR_EN.
package ace_snoop_pkg;
  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef struct packed { addr_t addr; logic [3:0] snoop; logic [2:0] prot; } ac_chan_t;
  typedef struct packed { data_t data; logic last; } cd_chan_t;
  typedef struct packed { logic ac_valid; ac_chan_t ac; logic cr_ready; logic cd_ready; } snoop_req_t;
  typedef struct packed {
    logic ac_ready; logic cr_valid; logic [4:0] cr_resp; logic cd_valid; cd_chan_t cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned BeatsPerLine = 4,
  parameter type ac_chan_t    = ace_snoop_pkg::ac_chan_t,
  parameter type cd_chan_t    = ace_snoop_pkg::cd_chan_t,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t,
  parameter type data_t       = ace_snoop_pkg::data_t
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  snoop_req_t                      snoop_req_i,
  output snoop_resp_t                     snoop_resp_o,
  output logic                            lkp_valid_o,
  input  logic                            lkp_ready_i,
  output logic [AddrWidth-1:0]            lkp_addr_o,
  input  logic                            lkp_rvalid_i,
  input  logic                            lkp_hit_i,
  input  logic                            lkp_dirty_i,
  input  logic                            lkp_unique_i,
`ifdef ACE_SNOOP_RESP_ERR_EN
  input  logic                            lkp_err_i,
`endif
  output logic                            rd_req_o,
  input  logic                            rd_gnt_i,
  output logic [$clog2(BeatsPerLine)-1:0] rd_beat_o,
  input  logic                            rd_rvalid_i,
  input  data_t                           rd_rdata_i,
  output logic                            upd_valid_o,
  input  logic                            upd_ready_i,
  output logic [1:0]                      upd_op_o
);
  localparam int unsigned BW   = $clog2(BeatsPerLine);
  localparam int unsigned OFFS = $clog2(BeatsPerLine * ($bits(data_t) / 8));
  localparam logic [AddrWidth-1:0] LineMask = ~((AddrWidth'(1) << OFFS) - AddrWidth'(1));
  localparam logic [BW-1:0] LastBeat = BW'(BeatsPerLine - 1);
  localparam logic [1:0] OpNone = 2'd0, OpInv = 2'd1, OpShr = 2'd2, OpCln = 2'd3;

  typedef enum logic [2:0] { S_IDLE, S_LKP, S_LKP_WAIT, S_CR, S_DATA, S_UPD } state_e;

  state_e                r_state, w_next;
  logic [AddrWidth-1:0]  r_addr;
  logic [3:0]            r_snoop;
  logic [4:0]            r_resp, w_resp;
  logic [1:0]            r_op, w_op;
  logic [BW-1:0]         r_beat;
  logic                  r_rd_busy, r_rd_last, r_rd_done;
  logic                  r_cd_valid, r_cd_last;
  data_t                 r_cd_data;
  logic                  w_rd_req, w_rd_fire, w_rd_ret, w_cd_fire;

  // Snoop decision; cr_resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  always_comb begin
    w_resp = '0;
    w_op   = OpNone;
    if (lkp_hit_i) begin
      case (r_snoop)
        4'b0000: w_resp = {lkp_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
        4'b0001, 4'b0010, 4'b0011: begin
          w_resp = {lkp_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
          w_op   = OpShr;
        end
        4'b0111: begin
          w_resp = {lkp_unique_i, 1'b0, lkp_dirty_i, 1'b0, 1'b1};
          w_op   = OpInv;
        end
        4'b1001: begin
          w_resp = {2'b00, lkp_dirty_i, 1'b0, lkp_dirty_i};
          w_op   = OpInv;
        end
        4'b1000: begin
          w_resp = {1'b0, 1'b1, lkp_dirty_i, 1'b0, lkp_dirty_i};
          w_op   = lkp_dirty_i ? OpCln : OpNone;
        end
        4'b1101: w_op = OpInv;
        default: ;
      endcase
    end
`ifdef ACE_SNOOP_RESP_ERR_EN
    if (lkp_err_i) begin
      w_resp = 5'b00010;
      w_op   = OpNone;
    end
`endif
  end

  // A new beat read only when no read is in flight and the CD slot is free or draining now.
  assign w_cd_fire = r_cd_valid & snoop_req_i.cd_ready;
  assign w_rd_req  = (r_state == S_DATA) & ~r_rd_busy & ~r_rd_done & (~r_cd_valid | snoop_req_i.cd_ready);
  assign w_rd_fire = w_rd_req & rd_gnt_i;
  assign w_rd_ret  = r_rd_busy & rd_rvalid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (snoop_req_i.ac_valid) w_next = S_LKP;
      S_LKP:      if (lkp_ready_i) w_next = S_LKP_WAIT;
      S_LKP_WAIT: if (lkp_rvalid_i) w_next = S_CR;
      S_CR:       if (snoop_req_i.cr_ready)
                    w_next = r_resp[0] ? S_DATA : ((r_op != OpNone) ? S_UPD : S_IDLE);
      S_DATA:     if (w_cd_fire && r_cd_last) w_next = (r_op != OpNone) ? S_UPD : S_IDLE;
      S_UPD:      if (upd_ready_i) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (r_state == S_IDLE);
    snoop_resp_o.cr_valid = (r_state == S_CR);
    snoop_resp_o.cr_resp  = r_resp;
    snoop_resp_o.cd_valid = r_cd_valid;
    snoop_resp_o.cd.data  = r_cd_data;
    snoop_resp_o.cd.last  = r_cd_last;
    lkp_valid_o           = (r_state == S_LKP);
    lkp_addr_o            = r_addr;
    rd_req_o              = w_rd_req;
    rd_beat_o             = r_beat;
    upd_valid_o           = (r_state == S_UPD);
    upd_op_o              = r_op;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr     <= '0;
      r_snoop    <= '0;
      r_resp     <= '0;
      r_op       <= '0;
      r_beat     <= '0;
      r_rd_busy  <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_cd_valid <= 1'b0;
      r_cd_last  <= 1'b0;
      r_cd_data  <= '0;
    end else begin
      if (r_state == S_IDLE && snoop_req_i.ac_valid) begin
        r_addr  <= snoop_req_i.ac.addr[AddrWidth-1:0] & LineMask;
        r_snoop <= snoop_req_i.ac.snoop;
      end
      if (r_state == S_LKP_WAIT && lkp_rvalid_i) begin
        r_resp <= w_resp;
        r_op   <= w_op;
      end
      if (r_state == S_CR) r_rd_done <= 1'b0;
      if (w_rd_fire) begin
        r_beat    <= r_beat + 1'b1;
        r_rd_busy <= 1'b1;
        r_rd_last <= (r_beat == LastBeat);
        if (r_beat == LastBeat) r_rd_done <= 1'b1;
      end
      if (w_rd_ret) begin
        r_rd_busy  <= 1'b0;
        r_cd_valid <= 1'b1;
        r_cd_data  <= rd_rdata_i;
        r_cd_last  <= r_rd_last;
      end else if (w_cd_fire) begin
        r_cd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Scoreboard bench for ace_snoop_responder: directed snoops push expected LKP/CR/CD/UPD
// events; a negedge monitor pops and compares on every DUT handshake.
module tb_ace_snoop_responder;
  localparam int K_LKP = 0, K_CR = 1, K_CD = 2, K_UPD = 3;
  typedef struct { int kind; logic [63:0] val; logic last; } ev_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  ace_snoop_pkg::snoop_req_t  req;
  ace_snoop_pkg::snoop_resp_t resp;
  logic        ac_valid = 0;
  logic [63:0] ac_addr = '0;
  logic [3:0]  ac_snoop = '0;
  logic        cr_ready = 0, cd_ready = 0;
  logic        lkp_valid, lkp_ready = 0, lkp_rvalid = 0, hit = 0, dirty = 0, uniq = 0, lkp_err = 0;
  logic [63:0] lkp_addr;
  logic        rd_req, rd_gnt = 0, rd_rvalid = 0;
  logic [1:0]  rd_beat;
  logic [63:0] rd_rdata = '0;
  logic        upd_valid, upd_ready = 0;
  logic [1:0]  upd_op;

  assign req = {ac_valid, ac_addr, ac_snoop, 3'b000, cr_ready, cd_ready};

  ace_snoop_responder dut (
    .clk_i(clk), .rst_i(rst), .snoop_req_i(req), .snoop_resp_o(resp),
    .lkp_valid_o(lkp_valid), .lkp_ready_i(lkp_ready), .lkp_addr_o(lkp_addr),
    .lkp_rvalid_i(lkp_rvalid), .lkp_hit_i(hit), .lkp_dirty_i(dirty), .lkp_unique_i(uniq),
`ifdef ACE_SNOOP_RESP_ERR_EN
    .lkp_err_i(lkp_err),
`endif
    .rd_req_o(rd_req), .rd_gnt_i(rd_gnt), .rd_beat_o(rd_beat),
    .rd_rvalid_i(rd_rvalid), .rd_rdata_i(rd_rdata),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_op_o(upd_op)
  );

  int   checks = 0, errors = 0;
  ev_t  exp_q[$];
  int   cr_hold = 0;
  logic cd_toggle = 0;
  logic [63:0] data_base = '0;

  // Cache/interconnect model: samples handshakes at negedge, drives at posedge+1.
  logic       lkp_fire_q = 0, rd_fire_q = 0;
  logic [1:0] rd_beat_q = '0, rd_beat_l = '0;
  int         lkp_cnt = 0, rd_cnt = 0, stall = 0;

  always @(negedge clk) begin
    lkp_fire_q = lkp_valid & lkp_ready;
    rd_fire_q  = rd_req & rd_gnt;
    rd_beat_q  = rd_beat;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      lkp_cnt = 0; rd_cnt = 0; stall = 0;
      lkp_rvalid = 0; rd_rvalid = 0; lkp_ready = 0; rd_gnt = 0;
      upd_ready = 0; cr_ready = 0; cd_ready = 0;
    end else begin
      lkp_rvalid = 0; rd_rvalid = 0;
      if (lkp_cnt > 0) begin lkp_cnt--; lkp_rvalid = (lkp_cnt == 0); end
      if (lkp_fire_q) lkp_cnt = 2;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin rd_rvalid = 1; rd_rdata = data_base + 64'(rd_beat_l); end
      end
      if (rd_fire_q) begin rd_cnt = 1; rd_beat_l = rd_beat_q; end
      lkp_ready = ~lkp_ready;
      rd_gnt    = ~rd_gnt;
      upd_ready = ~upd_ready;
      if (resp.cr_valid) stall++; else stall = 0;
      cr_ready  = (stall > cr_hold);
      cd_ready  = cd_toggle ? ~cd_ready : 1'b1;
    end
  end

  task automatic check_ev(input int kind, input logic [63:0] val, input logic last, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected handshake val=%h", nm, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.last != last) begin
        errors++;
        $display("FAIL %s: got kind=%0d val=%h last=%b, exp kind=%0d val=%h last=%b",
                 nm, kind, val, last, e.kind, e.val, e.last);
      end
    end
  endtask

  logic       prev_stall = 0;
  logic [4:0] prev_resp = '0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (resp.cr_valid || resp.cd_valid || lkp_valid || rd_req || upd_valid ||
          resp.cr_resp != 0 || resp.cd != '0 || lkp_addr != 0 || rd_beat != 0) begin
        errors++;
        $display("FAIL reset_outputs: cr_v=%b cd_v=%b lkp_v=%b rd_req=%b upd_v=%b resp=%b beat=%0d, exp all 0",
                 resp.cr_valid, resp.cd_valid, lkp_valid, rd_req, upd_valid, resp.cr_resp, rd_beat);
      end
      prev_stall = 0;
    end else begin
      if (lkp_valid && lkp_ready) check_ev(K_LKP, lkp_addr, 1'b0, "lkp_addr");
      if (resp.cr_valid && cr_ready) check_ev(K_CR, 64'(resp.cr_resp), 1'b0, "cr_resp");
      if (resp.cd_valid && cd_ready) check_ev(K_CD, resp.cd.data, resp.cd.last, "cd_beat");
      if (upd_valid && upd_ready) check_ev(K_UPD, 64'(upd_op), 1'b0, "upd_op");
      if (prev_stall) begin
        checks++;
        if (!resp.cr_valid || resp.cr_resp != prev_resp) begin
          errors++;
          $display("FAIL cr_stable: valid=%b resp=%b, exp valid=1 resp=%b", resp.cr_valid, resp.cr_resp, prev_resp);
        end
      end
      if (resp.cd_valid && !cd_ready) begin
        checks++;
        if (rd_req) begin
          errors++;
          $display("FAIL rd_overlap: rd_req=1 while CD beat pending, exp rd_req=0");
        end
      end
      prev_stall = resp.cr_valid && !cr_ready;
      prev_resp  = resp.cr_resp;
    end
  end

  task automatic push(input int kind, input logic [63:0] val, input logic last);
    ev_t e;
    e.kind = kind; e.val = val; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [63:0] addr, input logic [3:0] code);
    ac_addr = addr; ac_snoop = code; ac_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp.ac_ready) break;
    end
    @(posedge clk); #1;
    ac_valid = 0;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d events outstanding, exp 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic snoop(input logic [63:0] addr, input logic [3:0] code, input logic h, d, u,
                       input logic [4:0] exp_resp, input int nbeats, input logic [1:0] exp_op,
                       input logic [63:0] base, input string nm);
    hit = h; dirty = d; uniq = u; data_base = base;
    push(K_LKP, addr & ~64'h1F, 1'b0);
    push(K_CR, 64'(exp_resp), 1'b0);
    for (int b = 0; b < nbeats; b++) push(K_CD, base + 64'(b), b == nbeats - 1);
    if (exp_op != 0) push(K_UPD, 64'(exp_op), 1'b0);
    issue(addr, code);
    wait_empty(nm);
    // The final handshake returns the FSM straight to IDLE.
    checks++;
    if (!resp.ac_ready) begin
      errors++;
      $display("FAIL %s_idle: ac_ready=%b, exp 1", nm, resp.ac_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    snoop(64'h1000_0047, 4'b0001, 1, 0, 1, 5'b11001, 4, 2'd2, 64'h0,    "read_shared");
    snoop(64'h2000_00A5, 4'b0111, 1, 1, 0, 5'b00101, 4, 2'd1, 64'h100,  "read_unique");
    snoop(64'h3000_0010, 4'b0001, 0, 1, 1, 5'b00000, 0, 2'd0, 64'h0,    "miss");
    cr_hold = 5;
    snoop(64'h4000_0020, 4'b1000, 1, 0, 0, 5'b01000, 0, 2'd0, 64'h0,    "clean_shared_stall");
    cr_hold = 0;
    snoop(64'h5000_003F, 4'b1001, 1, 1, 0, 5'b00101, 4, 2'd1, 64'h200,  "clean_invalid");
    snoop(64'h6000_0000, 4'b1000, 1, 1, 1, 5'b01101, 4, 2'd3, 64'h300,  "clean_shared_dirty");
    snoop(64'h7000_0000, 4'b0101, 1, 1, 1, 5'b00000, 0, 2'd0, 64'h0,    "unlisted");
`ifdef ACE_SNOOP_RESP_ERR_EN
    lkp_err = 1;
    snoop(64'h8000_0000, 4'b1101, 1, 1, 1, 5'b00010, 0, 2'd0, 64'h0,    "make_invalid_err");
    lkp_err = 0;
`else
    snoop(64'h8000_0000, 4'b1101, 1, 1, 1, 5'b00000, 0, 2'd1, 64'h0,    "make_invalid");
`endif
    // ReadOnce with backpressure, reset after beat 1 is accepted (beat 2 in flight).
    cd_toggle = 1;
    hit = 1; dirty = 0; uniq = 1; data_base = 64'h400;
    push(K_LKP, 64'h9000_0040, 1'b0);
    push(K_CR, 64'(5'b11001), 1'b0);
    push(K_CD, 64'h400, 1'b0);
    push(K_CD, 64'h401, 1'b0);
    issue(64'h9000_0044, 4'b0000);
    wait_empty("read_once_partial");
    rst = 1;
    #1;
    checks++;
    if (resp.cr_valid || resp.cd_valid || rd_req || upd_valid || lkp_valid) begin
      errors++;
      $display("FAIL mid_reset: cr_v=%b cd_v=%b rd_req=%b upd_v=%b lkp_v=%b, exp all 0",
               resp.cr_valid, resp.cd_valid, rd_req, upd_valid, lkp_valid);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (!resp.ac_ready) begin
      errors++;
      $display("FAIL post_reset_idle: ac_ready=%b, exp 1", resp.ac_ready);
    end
    @(posedge clk); #1;
    snoop(64'hA000_0060, 4'b0011, 1, 1, 1, 5'b11001, 4, 2'd2, 64'h500, "read_nsd_toggle");
    snoop(64'hB000_0000, 4'b0000, 1, 0, 0, 5'b01001, 4, 2'd0, 64'h600, "read_once_full");
    cd_toggle = 0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Cache-side endpoint of the ACE snoop channels. It sits at a cached master's snoop port and answers the CCU snoop interconnect.
- Accepts one AC snoop at a time and queries the local cache tag/state through a lookup port.
- Returns a CR response and, when the line supplies data, a CD burst read beat-by-beat from the cache data array.
- Afterwards issues the required line-state update (invalidate / make-shared / clean).

Parameters:
- AddrWidth, 64, width of AC address and lookup address.
- BeatsPerLine, 4, CD beats per cache line (power of two, ≥2).
- ac_chan_t, logic, AC channel struct (addr, snoop[3:0], prot).
- cd_chan_t, logic, CD channel struct (data, last).
- snoop_req_t, logic, {ac_valid, ac, cr_ready, cd_ready}.
- snoop_resp_t, logic, {ac_ready, cr_valid, cr_resp[4:0], cd_valid, cd}.
- data_t, logic, one CD beat of data.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- snoop_req_i  in  snoop_req_t  AC/ready side from the snoop interconnect
- snoop_resp_o  out  snoop_resp_t  ac_ready, CR, CD toward the interconnect
- lkp_valid_o  out  1  tag lookup request
- lkp_ready_i  in  1  lookup accepted
- lkp_addr_o  out  AddrWidth  line-aligned snoop address
- lkp_rvalid_i  in  1  lookup result valid (one pulse, ≥1 cycle after accept)
- lkp_hit_i  in  1  line present
- lkp_dirty_i  in  1  line dirty
- lkp_unique_i  in  1  line unique
- rd_req_o  out  1  data-array beat read request
- rd_gnt_i  in  1  read accepted
- rd_beat_o  out  $clog2(BeatsPerLine)  beat index
- rd_rvalid_i  in  1  read data valid
- rd_rdata_i  in  data_t  read data
- upd_valid_o  out  1  state update request
- upd_ready_i  in  1  update accepted
- upd_op_o  out  2  0 none, 1 invalidate, 2 make-shared (clear unique), 3 clean (clear dirty)

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All valid/req outputs are 0; cr_resp, cd, lkp_addr_o and rd_beat_o are 0.
  - A reset mid-transaction abandons it with no further outputs.
- FSM states: IDLE, LKP, LKP_WAIT, CR, DATA, UPD.
- IDLE:
  - ac_ready=1.
  - On ac_valid&ac_ready, latch addr (low log2(BeatsPerLine·bytes) bits cleared) and snoop; go to LKP.
- LKP:
  - lkp_valid_o=1, held stable until lkp_ready_i; then go to LKP_WAIT.
- LKP_WAIT:
  - On lkp_rvalid_i, compute the response and go to CR.
  - The response is registered: CR is visible at the earliest the cycle after rvalid.
- cr_resp bit order is {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
- Decision by snoop code:
  - Miss or unlisted code: cr_resp=0, no data, op none.
  - ReadOnce 0000: DT=1, IsShared=1, WasUnique=unique; op none.
  - ReadShared 0001 / ReadClean 0010 / ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=0, WasUnique=unique; op make-shared.
  - ReadUnique 0111: DT=1, PassDirty=dirty, WasUnique=unique; op invalidate.
  - CleanInvalid 1001: DT=dirty, PassDirty=dirty; op invalidate.
  - CleanShared 1000: DT=dirty, PassDirty=dirty, IsShared=1; op clean if dirty, else none.
  - MakeInvalid 1101: DT=0; op invalidate.
- CR:
  - cr_valid=1 with stable cr_resp until cr_ready.
  - On handshake go to DATA if DT, else to UPD if op≠none, else to IDLE.
- DATA:
  - For beat b = 0..BeatsPerLine-1 in order, assert rd_req_o with rd_beat_o=b until rd_gnt_i.
  - On rd_rvalid_i, register the beat into cd.data; cd.last=1 iff b=BeatsPerLine-1.
  - Hold cd_valid until cd_ready.
  - One read outstanding at most; the next rd_req_o is asserted in the cycle of the cd handshake at the earliest.
  - After the last beat handshake go to UPD if op≠none, else IDLE.
- UPD:
  - upd_valid_o=1 with upd_op_o until upd_ready_i, then go to IDLE.
- Handshakes never drop valid before ready.
- The beat counter wraps to 0 on the last beat.
- CD never starts before the CR handshake.
- Back-to-back snoops: IDLE is entered for ≥1 cycle between transactions (ac_ready low while busy).

Optional Feature:
- Macro: ACE_SNOOP_RESP_ERR_EN.
- When defined:
  - Extra input lkp_err_i (1), sampled with lkp_rvalid_i.
  - If set, cr_resp = 5'b00010 (Error only): DT forced 0, op forced none, FSM goes CR→IDLE.
- When undefined: port absent, Error bit is always 0.

Test Plan:
- ReadShared, hit, clean, unique → cr_resp=5'b11001; 4 CD beats with data 0..3 from rd_rdata_i, last on beat 3; upd_op_o=2; ac_ready returns high afterwards.
- ReadUnique, hit, dirty, shared → cr_resp=5'b00101; 4 beats; upd_op_o=1.
- Any snoop, miss → cr_resp=0; no rd_req_o; no upd_valid_o; back to IDLE the cycle after the cr handshake.
- CleanShared, hit, clean, with cr_ready low for 5 cycles → cr_valid and cr_resp=5'b01000 held stable; no CD; no update.
- ReadOnce, hit, with cd_ready toggled every other cycle → no beat lost or duplicated; rd_req_o never overlaps an unaccepted CD beat; reset asserted during beat 2 → all valids 0 immediately, IDLE after release.
- With ACE_SNOOP_RESP_ERR_EN, MakeInvalid with lkp_err_i=1 → cr_resp=5'b00010; no data; no upd_valid_o.
